// File: rtl/soc_evt_arbiter.sv
// rtl/soc_evt_arbiter.sv - per-source saturating event counters serialised round-robin onto one valid/ready ID stream
module soc_evt_arbiter #(
  parameter int NB_SRC     = 16,
  parameter int EVNT_WIDTH = 8,
  parameter int CNT_W      = 2,
  parameter int ID_BASE    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NB_SRC-1:0]     evt_i,
  input  logic [NB_SRC-1:0]     evt_mask_i,
  input  logic [NB_SRC-1:0]     ovf_clr_i,
  output logic [NB_SRC-1:0]     evt_overflow_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [EVNT_WIDTH-1:0] evt_data_o,
  output logic                  busy_o
);

  localparam int PTR_W = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NB_SRC - 1);

  logic [CNT_W-1:0]      pend [NB_SRC];
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W-1:0]      next_ptr;
  logic                  found;
  logic                  load_en;
  logic                  load;
  logic [NB_SRC-1:0]     inc;
  logic [NB_SRC-1:0]     dec;
  logic [NB_SRC-1:0]     sat;
  logic [NB_SRC-1:0]     lost;
  logic [EVNT_WIDTH-1:0] win_id;

  // Rotating priority search over registered counts, starting at rr_ptr.
  always_comb begin : arb_search
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NB_SRC; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NB_SRC) begin
        idx = idx - NB_SRC;
      end
      if (!found && (pend[idx] != '0)) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  assign inc      = evt_i & evt_mask_i;
  assign load_en  = !evt_valid_o || evt_ready_i;
  assign load     = load_en && found;
  assign next_ptr = (winner == LAST_SRC) ? '0 : winner + PTR_W'(1);
  assign win_id   = EVNT_WIDTH'(ID_BASE) + EVNT_WIDTH'(winner);

  always_comb begin
    dec = '0;
    sat = '0;
    if (load) begin
      dec[winner] = 1'b1;
    end
    for (int s = 0; s < NB_SRC; s++) begin
      sat[s] = (pend[s] == CNT_MAX);
    end
  end

  // An increment is only lost when it cannot be absorbed by a same-cycle drain.
  assign lost   = inc & ~dec & sat;
  assign busy_o = found || evt_valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NB_SRC; s++) begin
        pend[s] <= '0;
      end
      evt_overflow_o <= '0;
    end else begin
      for (int s = 0; s < NB_SRC; s++) begin
        if (inc[s] && !dec[s]) begin
          if (!sat[s]) begin
            pend[s] <= pend[s] + CNT_W'(1);
          end
        end else if (dec[s] && !inc[s]) begin
          pend[s] <= pend[s] - CNT_W'(1);
        end
        if (lost[s]) begin
          evt_overflow_o[s] <= 1'b1;
        end else if (ovf_clr_i[s]) begin
          evt_overflow_o[s] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      evt_valid_o <= 1'b0;
      evt_data_o  <= '0;
    end else if (load) begin
      rr_ptr      <= next_ptr;
      evt_valid_o <= 1'b1;
      evt_data_o  <= win_id;
    end else if (load_en) begin
      evt_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_soc_evt_arbiter.sv
// tb/tb_soc_evt_arbiter.sv - directed self-checking bench for soc_evt_arbiter (NB_SRC=16, CNT_W=2, ID_BASE=4)
module tb_soc_evt_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] evt;
  logic [15:0] evt_mask;
  logic [15:0] ovf_clr;
  logic [15:0] evt_overflow;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  soc_evt_arbiter #(
    .NB_SRC(16), .EVNT_WIDTH(8), .CNT_W(2), .ID_BASE(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .evt_i(evt), .evt_mask_i(evt_mask),
    .ovf_clr_i(ovf_clr), .evt_overflow_o(evt_overflow),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
    .evt_data_o(evt_data), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; evt = '0; evt_mask = '1; ovf_clr = '0; evt_ready = 1'b1;
    tick();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_ovf", 32'(evt_overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;

    // latency and ID offset
    evt = 16'h0008;
    tick();
    evt = '0;
    check("lat_valid_early", 32'(evt_valid), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    tick();
    check("lat_valid", 32'(evt_valid), 32'd1);
    check("lat_data", 32'(evt_data), 32'd7);
    tick();
    check("lat_one_beat", 32'(evt_valid), 32'd0);
    check("lat_idle", 32'(busy), 32'd0);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // round robin from pointer 0
    evt = 16'h8021;
    tick();
    evt = '0;
    tick();
    check("rr_a0", 32'(evt_data), 32'd4);
    check("rr_a0_v", 32'(evt_valid), 32'd1);
    tick();
    check("rr_a5", 32'(evt_data), 32'd9);
    tick();
    check("rr_a15", 32'(evt_data), 32'd19);
    tick();
    check("rr_a_end", 32'(evt_valid), 32'd0);
    evt = 16'h8001;
    tick();
    evt = '0;
    tick();
    check("rr_b0", 32'(evt_data), 32'd4);
    tick();
    check("rr_b15", 32'(evt_data), 32'd19);
    check("rr_b15_v", 32'(evt_valid), 32'd1);
    tick();
    check("rr_b_end", 32'(evt_valid), 32'd0);

    // backpressure with sources 1,2,3 pending
    evt_ready = 1'b0;
    evt = 16'h000E;
    tick();
    evt = '0;
    check("bp_not_yet", 32'(evt_valid), 32'd0);
    tick();
    check("bp_first", 32'(evt_data), 32'd5);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold_v", 32'(evt_valid), 32'd1);
      check("bp_hold_d", 32'(evt_data), 32'd5);
    end
    evt_ready = 1'b1;
    tick();
    check("bp_beat2", 32'(evt_data), 32'd6);
    tick();
    check("bp_beat3", 32'(evt_data), 32'd7);
    check("bp_beat3_v", 32'(evt_valid), 32'd1);
    tick();
    check("bp_end", 32'(evt_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);

    // saturation of source 2
    evt_ready = 1'b0;
    evt = 16'h0004;
    for (int i = 0; i < 4; i++) tick();
    check("sat_no_ovf_yet", 32'(evt_overflow), 32'd0);
    tick();
    evt = '0;
    check("sat_ovf", 32'(evt_overflow), 32'h0004);
    check("sat_latched", 32'(evt_data), 32'd6);
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_beat_v", 32'(evt_valid), 32'd1);
      check("sat_beat_d", 32'(evt_data), 32'd6);
    end
    tick();
    check("sat_end", 32'(evt_valid), 32'd0);
    check("sat_ovf_sticky", 32'(evt_overflow), 32'h0004);
    ovf_clr = 16'h0004;
    tick();
    ovf_clr = '0;
    check("sat_ovf_clr", 32'(evt_overflow), 32'd0);

    // inc/dec collision on source 1
    evt = 16'h0002;
    tick();
    check("col_not_yet", 32'(evt_valid), 32'd0);
    tick();
    evt = '0;
    check("col_beat1_v", 32'(evt_valid), 32'd1);
    check("col_beat1_d", 32'(evt_data), 32'd5);
    tick();
    check("col_beat2_v", 32'(evt_valid), 32'd1);
    check("col_beat2_d", 32'(evt_data), 32'd5);
    tick();
    check("col_end", 32'(evt_valid), 32'd0);
    check("col_idle", 32'(busy), 32'd0);

    // masked pulses ignored, existing count still drains
    evt_ready = 1'b0;
    evt = 16'h0002;
    tick();
    tick();
    evt_mask = 16'hFFFD;
    tick();
    tick();
    evt = '0;
    check("mask_hold_v", 32'(evt_valid), 32'd1);
    check("mask_busy", 32'(busy), 32'd1);
    evt_ready = 1'b1;
    tick();
    check("mask_drain_v", 32'(evt_valid), 32'd1);
    check("mask_drain_d", 32'(evt_data), 32'd5);
    tick();
    check("mask_end", 32'(evt_valid), 32'd0);
    check("mask_idle", 32'(busy), 32'd0);
    evt_mask = '1;

    // reset in the middle of traffic
    evt_ready = 1'b0;
    evt = 16'h00C0;
    for (int i = 0; i < 5; i++) tick();
    evt = '0;
    check("mid_ovf", 32'(evt_overflow), 32'h00C0);
    check("mid_valid", 32'(evt_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    check("mid_rst_data", 32'(evt_data), 32'd0);
    check("mid_rst_ovf", 32'(evt_overflow), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_valid", 32'(evt_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
